// File: rtl/framebuffer_write_ctrl_pkg.sv
// Shared constants and state encoding for the framebuffer write path.
// The frame is 64x32 RGB565 pixels stored as 4096 bytes, low byte at the even address.
package framebuffer_write_ctrl_pkg;

  localparam int FB_WIDTH       = 64;
  localparam int FB_HEIGHT      = 32;
  localparam int FB_ADDR_WIDTH  = 12;
  localparam int FB_DATA_WIDTH  = 8;
  localparam int FB_FRAME_BYTES = FB_WIDTH * FB_HEIGHT * 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fb_state_t;

endpackage

// File: rtl/framebuffer_write_ctrl_fill_engine.sv
// Full-frame fill source: latches one RGB565 colour and walks every byte address,
// presenting the matching byte lane for each address.
module fb_fill_engine
  import framebuffer_write_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = FB_DATA_WIDTH,
  parameter int FRAME_BYTES = FB_FRAME_BYTES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    run,
  input  logic [2*DATA_WIDTH-1:0] color,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_BYTES - 1);

  logic [ADDR_WIDTH-1:0]   count_p0;
  logic [2*DATA_WIDTH-1:0] color_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_p0 <= '0;
    end else if (start) begin
      count_p0 <= '0;
    end else if (run) begin
      count_p0 <= last ? '0 : count_p0 + 1'b1;
    end
  end

  // Colour is pure data and only meaningful once start has loaded it.
  always_ff @(posedge clk) begin
    if (start) begin
      color_p0 <= color;
    end
  end

  assign addr = count_p0;
  assign data = count_p0[0] ? color_p0[2*DATA_WIDTH-1:DATA_WIDTH] : color_p0[DATA_WIDTH-1:0];
  assign last = run && (count_p0 == LAST_ADDR);

endmodule

// File: rtl/framebuffer_write_ctrl.sv
// Port-A write controller for the framebuffer RAM: arbitrates the UART byte stream
// against the fill engine, drives registered RAM strobes and flags frame completion.
module framebuffer_write_ctrl
  import framebuffer_write_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = FB_DATA_WIDTH,
  parameter int FRAME_BYTES = FB_FRAME_BYTES
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    byte_valid,
  input  logic [DATA_WIDTH-1:0]   byte_data,
  output logic                    byte_ready,
  input  logic                    fill_start,
  input  logic [2*DATA_WIDTH-1:0] fill_color,
  output logic                    fill_busy,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_data,
  output logic                    ram_clk_enable,
  output logic                    ram_wr,
  output logic                    frame_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_BYTES - 1);

  fb_state_t             state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] stream_addr;
  logic                  accept;
  logic                  fill_go;
  logic                  fill_run;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  fill_last;

  // A fill request in the same cycle wins over the stream byte.
  assign byte_ready  = reset && (state == ST_IDLE) && !fill_start;
  assign accept      = byte_valid && byte_ready;
  assign fill_go     = (state == ST_IDLE) && fill_start;
  assign fill_run    = (state == ST_FILL);
  assign stream_addr = frame_start ? '0 : ptr;

  fb_fill_engine #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAME_BYTES(FRAME_BYTES)
  ) u_fill (
    .clk  (clk_in),
    .rst_n(reset),
    .start(fill_go),
    .run  (fill_run),
    .color(fill_color),
    .addr (fill_addr),
    .data (fill_data),
    .last (fill_last)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      ram_addr       <= '0;
      ram_data       <= '0;
      ram_wr         <= 1'b0;
      ram_clk_enable <= 1'b0;
      fill_busy      <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      ram_wr         <= 1'b0;
      ram_clk_enable <= 1'b0;
      frame_done     <= 1'b0;
      // Busy covers the issue cycles plus the cycle in which the final write is visible.
      fill_busy      <= fill_go || fill_run;
      case (state)
        ST_IDLE: begin
          if (fill_go) begin
            state <= ST_FILL;
          end
          if (accept) begin
            ram_wr         <= 1'b1;
            ram_clk_enable <= 1'b1;
            ram_addr       <= stream_addr;
            ram_data       <= byte_data;
            frame_done     <= (stream_addr == LAST_ADDR);
            ptr            <= (stream_addr == LAST_ADDR) ? '0 : stream_addr + 1'b1;
          end else if (frame_start) begin
            ptr <= '0;
          end
        end
        ST_FILL: begin
          ram_wr         <= 1'b1;
          ram_clk_enable <= 1'b1;
          ram_addr       <= fill_addr;
          ram_data       <= fill_data;
          if (fill_last) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
            ptr        <= '0;
          end else if (frame_start) begin
            ptr <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
